// File: rtl/sdram_ch_bridge_pkg.sv
// Shared types for the SDRAM channel bridge: FSM states and the queued client request.
package sdram_ch_bridge_pkg;

    typedef enum logic [1:0] {
        DRAIN,
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    typedef struct packed {
        logic        we;
        logic [24:0] addr;
        logic [7:0]  din;
    } req_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Request FIFO for the SDRAM channel bridge; count-based full/empty, pointers wrap modulo DEPTH.
module sdram_req_fifo
    import sdram_ch_bridge_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = req_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop while full does not free the slot for a same-cycle push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/sdram_ch_bridge.sv
// Byte-wide client to SDRAM controller channel bridge: queues requests and issues
// one level strobe per access, waiting out the controller's busy handshake.
module sdram_ch_bridge
    import sdram_ch_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [24:0] req_addr,
    input  logic [7:0]  req_din,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [24:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    input  logic        mem_busy
);
    state_t      state, state_n;
    req_t        req_in, head;
    logic        full, empty, pop;
    logic        we_q, we_n;
    logic        rd_n, wr_n, rsp_v_n;
    logic [24:0] addr_n;
    logic [7:0]  din_n, rsp_d_n;

    assign req_ready = !full && !reset;
    assign req_in    = '{we: req_we, addr: req_addr, din: req_din};

    sdram_req_fifo #(.DEPTH(DEPTH), .T(req_t)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid && req_ready),
        .din   (req_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        rd_n    = mem_rd;
        wr_n    = mem_wr;
        addr_n  = mem_addr;
        din_n   = mem_din;
        we_n    = we_q;
        rsp_v_n = 1'b0;
        rsp_d_n = rsp_data;
        case (state)
            DRAIN: begin
                if (!mem_busy) state_n = IDLE;
            end
            IDLE: begin
                if (!empty) begin
                    state_n = ISSUE;
                    pop     = 1'b1;
                    addr_n  = head.addr;
                    din_n   = head.din;
                    we_n    = head.we;
                    rd_n    = !head.we;
                    wr_n    = head.we;
                end
            end
            ISSUE: begin
                // Strobe is held until the controller acknowledges with busy.
                if (mem_busy) begin
                    state_n = WAIT_DONE;
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                end
            end
            WAIT_DONE: begin
                rd_n = 1'b0;
                wr_n = 1'b0;
                if (!mem_busy) begin
                    state_n = IDLE;
                    if (!we_q) begin
                        rsp_v_n = 1'b1;
                        rsp_d_n = mem_dout;
                    end
                end
            end
            default: state_n = DRAIN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= DRAIN;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            we_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            mem_rd    <= rd_n;
            mem_wr    <= wr_n;
            mem_addr  <= addr_n;
            mem_din   <= din_n;
            we_q      <= we_n;
            rsp_valid <= rsp_v_n;
            rsp_data  <= rsp_d_n;
        end
    end

endmodule

// File: tb/tb_sdram_ch_bridge.sv
// Directed bench for sdram_ch_bridge with a behavioural controller channel model.
module tb_sdram_ch_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [24:0] req_addr = '0;
    logic [7:0]  req_din = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [24:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = '0;
    logic        mem_busy;

    logic        busy_m = 1'b0;
    logic        force_busy = 1'b0;
    int          dly_cfg = 1;
    int          hold_cfg = 6;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdram_ch_bridge #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_busy  (mem_busy)
    );

    assign mem_busy = busy_m | force_busy;

    // Unwritten locations read back a fixed function of the address.
    function automatic logic [7:0] bg_data(logic [24:0] a);
        return a[7:0] ^ 8'h86;
    endfunction

    // Controller model: busy rises dly_cfg cycles after a strobe rising edge, lasts hold_cfg cycles.
    logic [7:0]  mdl_mem [0:511];
    logic        mdl_vld [0:511];
    logic        prev_strobe = 1'b0;
    logic        waiting = 1'b0;
    logic        p_we = 1'b0;
    logic [24:0] p_addr = '0;
    logic [7:0]  p_din = '0;
    int          cnt_d = 0;
    int          cnt_h = 0;
    int          n_access = 0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        prev_strobe <= mem_rd | mem_wr;
        if ((mem_rd | mem_wr) && !prev_strobe) begin
            n_access <= n_access + 1;
            p_we     <= mem_wr;
            p_addr   <= mem_addr;
            p_din    <= mem_din;
            if (dly_cfg <= 1) begin
                busy_m <= 1'b1;
                cnt_h  <= hold_cfg;
            end else begin
                waiting <= 1'b1;
                cnt_d   <= dly_cfg - 1;
            end
        end else if (waiting) begin
            if (cnt_d <= 1) begin
                waiting <= 1'b0;
                busy_m  <= 1'b1;
                cnt_h   <= hold_cfg;
            end else begin
                cnt_d <= cnt_d - 1;
            end
        end else if (busy_m) begin
            if (cnt_h <= 1) begin
                busy_m <= 1'b0;
                if (p_we) begin
                    mdl_mem[{p_addr[24], p_addr[7:0]}] <= p_din;
                    mdl_vld[{p_addr[24], p_addr[7:0]}] <= 1'b1;
                end else begin
                    mem_dout <= (mdl_vld[{p_addr[24], p_addr[7:0]}] === 1'b1) ?
                                mdl_mem[{p_addr[24], p_addr[7:0]}] : bg_data(p_addr);
                end
            end else begin
                cnt_h <= cnt_h - 1;
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    logic [7:0] rsp_buf [0:63];
    int         rsp_cyc [0:63];
    int         n_rsp = 0;
    int         both_hi = 0;
    int         nogap = 0;
    int         rd_hi = 0;
    logic       prev_rd = 1'b0;
    logic       prev_wr = 1'b0;

    always @(negedge clk) begin
        prev_rd <= mem_rd;
        prev_wr <= mem_wr;
        if (mem_rd && mem_wr) both_hi <= both_hi + 1;
        if ((mem_rd && prev_wr) || (mem_wr && prev_rd)) nogap <= nogap + 1;
        if (mem_rd) rd_hi <= rd_hi + 1;
        if (rsp_valid) begin
            rsp_buf[n_rsp[5:0]] <= rsp_data;
            rsp_cyc[n_rsp[5:0]] <= cyc;
            n_rsp <= n_rsp + 1;
        end
    end

    function automatic logic [7:0] get_rsp(int k);
        return rsp_buf[k[5:0]];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int push_cyc = 0;

    // Called and returns at a falling edge; consecutive calls push back-to-back.
    task automatic push(logic we, logic [24:0] a, logic [7:0] d);
        int t = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_din   = d;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("push_ready", 32'(req_ready), 32'd1);
        push_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(int n);
        int t = 0;
        while (n_rsp < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("rsp_count", 32'(n_rsp), 32'(n));
    endtask

    initial begin
        int a0, r0, viol, t;
        logic [24:0] ta;

        repeat (3) @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rd", 32'(mem_rd), 32'd0);
        check("reset_wr", 32'(mem_wr), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        check("reset_din", 32'(mem_din), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Single read, busy 1 cycle after strobe, held 6 cycles
        a0 = n_access;
        r0 = rd_hi;
        push(1'b0, 25'h0000123, 8'h00);
        wait_rsp(1);
        repeat (4) @(negedge clk);
        check("rd1_single_rsp", 32'(n_rsp), 32'd1);
        check("rd1_data", 32'(get_rsp(0)), 32'hA5);
        check("rd1_latency", 32'(rsp_cyc[0] - push_cyc), 32'd10);
        check("rd1_accesses", 32'(n_access - a0), 32'd1);
        check("rd1_rd_hold", 32'(rd_hi - r0), 32'd2);

        // Write then read back the same top-of-range address
        a0 = n_access;
        push(1'b1, 25'h1000000, 8'h3C);
        push(1'b0, 25'h1000000, 8'h00);
        wait_rsp(2);
        repeat (4) @(negedge clk);
        check("wr_rd_rsp_count", 32'(n_rsp), 32'd2);
        check("wr_rd_data", 32'(get_rsp(1)), 32'h3C);
        check("wr_rd_accesses", 32'(n_access - a0), 32'd2);
        check("wr_rd_gap", 32'(nogap), 32'd0);

        // Fill the FIFO while the controller is stalled
        hold_cfg   = 2;
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(1'b0, 25'h10 + 25'(i), 8'h00);
        check("full_ready_low", 32'(req_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("full_ready_held", 32'(req_ready), 32'd0);
        check("full_no_rsp", 32'(n_rsp), 32'd2);
        force_busy = 1'b0;
        wait_rsp(7);
        for (int i = 0; i < 5; i++)
            check("full_order", 32'(get_rsp(2 + i)), 32'(bg_data(25'h10 + 25'(i))));

        // Controller slow to acknowledge: strobe held, no re-pulse
        hold_cfg = 3;
        dly_cfg  = 10;
        a0 = n_access;
        r0 = rd_hi;
        push(1'b0, 25'h0000123, 8'h00);
        wait_rsp(8);
        check("slow_ack_data", 32'(get_rsp(7)), 32'hA5);
        check("slow_ack_accesses", 32'(n_access - a0), 32'd1);
        check("slow_ack_rd_hold", 32'(rd_hi - r0), 32'd11);
        dly_cfg = 1;

        // Reset while waiting on busy: in-flight read discarded, DRAIN holds off issue
        hold_cfg = 8;
        a0 = n_access;
        push(1'b0, 25'h0000123, 8'h00);
        t = 0;
        while (!mem_busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rst_busy_seen", 32'(mem_busy), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_rd_low", 32'(mem_rd), 32'd0);
        check("rst_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 25'h1000000;
        viol = 0;
        t = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            if ((mem_rd || mem_wr) && mem_busy) viol++;
            t++;
        end while (mem_busy && t < 50);
        check("drain_no_strobe", 32'(viol), 32'd0);
        check("drain_busy_released", 32'(mem_busy), 32'd0);
        wait_rsp(9);
        repeat (5) @(negedge clk);
        check("rst_one_rsp", 32'(n_rsp), 32'd9);
        check("rst_after_data", 32'(get_rsp(8)), 32'h3C);
        check("rst_accesses", 32'(n_access - a0), 32'd2);

        // Alternating reads with random acknowledge delays
        for (int i = 0; i < 16; i++) begin
            dly_cfg  = int'($urandom_range(8, 2));
            hold_cfg = int'($urandom_range(4, 2));
            ta = 25'(i % 2);
            push(1'b0, ta, 8'h00);
            wait_rsp(10 + i);
            check("alt_data", 32'(get_rsp(9 + i)), 32'(bg_data(ta)));
        end
        check("never_both_high", 32'(both_hi), 32'd0);
        check("strobe_gap", 32'(nogap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
